// File: rtl/alu_issue_if.sv
// Request/response handshake bundle between the execute controller and alu_issue.
// master = control path (issues requests, consumes results), slave = alu_issue.
interface alu_issue_if #(
    parameter int WORD_SIZE = 16,
    parameter int TAG_WIDTH = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic [WORD_SIZE-1:0] req_a;
    logic [WORD_SIZE-1:0] req_b;
    logic [TAG_WIDTH-1:0] req_tag;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_result;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic                 rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_zero
    );
endinterface

// File: rtl/alu_issue.sv
// ALU operand initiator: issues one request to the alu, waits ALU_LATENCY edges,
// captures alu_out and returns it with the request tag. One operation in flight.
module alu_issue #(
    parameter int WORD_SIZE   = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_if.slave           bus,
    output logic [2:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic [15:0]          op_count
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t               state, state_d;
    logic [3:0]           cnt;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [15:0]          ops_q;
    logic                 accept, rsp_fire;

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_zero  = (bus.rsp_result == '0);
    assign accept        = bus.req_ready && bus.req_valid;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign op_count      = ops_q;

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (bus.req_valid) state_d = S_WAIT;
            S_WAIT:  if (cnt == 4'd0)   state_d = S_DONE;
            S_DONE:  if (rsp_fire)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
        end else begin
            state         <= state_d;
            bus.rsp_valid <= (state_d == S_DONE);
        end
    end

    // alu_* change only on acceptance, so they stay valid for the whole wait and stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op         <= '0;
            alu_in1        <= '0;
            alu_in2        <= '0;
            tag_q          <= '0;
            cnt            <= '0;
            bus.rsp_result <= '0;
            bus.rsp_tag    <= '0;
            ops_q          <= '0;
        end else begin
            if (accept) begin
                alu_op  <= bus.req_op;
                alu_in1 <= bus.req_a;
                alu_in2 <= bus.req_b;
                tag_q   <= bus.req_tag;
                cnt     <= 4'(ALU_LATENCY);
            end
            if (state == S_WAIT) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    bus.rsp_result <= alu_out;
                    bus.rsp_tag    <= tag_q;
                end
            end
            if (state == S_DONE && rsp_fire && ops_q != 16'hFFFF)
                ops_q <= ops_q + 16'd1;
        end
    end
endmodule
